// File: rtl/spi_slave_frame_if.sv
// Word-level side of spi_slave_frame: transmit source, receive sink and FSM state.
// Handshake: tx_data is consumed on the sys_clk edge where tx_valid & tx_ready are both high.
// rx_valid is a one-cycle strobe with no back-pressure; rx_data is held until the next strobe.
interface spi_slave_frame_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [1:0]        state_dbg;

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid,
    output state_dbg
  );

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid,
    input  state_dbg
  );
endinterface

// File: rtl/spi_slave_frame.sv
// SPI slave for multi-word frames: synchronises the pins into sys_clk, deserialises mosi
// into words and serialises words pulled from a valid/ready source onto miso.
module spi_slave_frame #(
  parameter int                DATA_W      = 8,
  parameter logic              CPOL        = 1'b1,
  parameter logic              CPHA        = 1'b1,
  parameter logic              MSB_FIRST   = 1'b1,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] TX_IDLE     = '0,
  parameter int                CNT_W       = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             cs_n,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  spi_slave_frame_if.slave bus,
  output logic             tx_underrun,
  output logic             frame_done,
  output logic             frame_abort,
  output logic [CNT_W-1:0] word_cnt,
  output logic             busy
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_END    = 2'd3;

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   cs_dly_q, cs_dly_d;
  logic                   sclk_dly_q, sclk_dly_d;

  logic [1:0]        state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              miso_oe_q, miso_oe_d;

  logic cs_s, sclk_s, mosi_s;
  logic cs_fall;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic tx_load, tx_shift_en;
  logic tx_bit;

  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    cs_dly_d    = cs_sync_q[SYNC_STAGES-1];
    sclk_dly_d  = sclk_sync_q[SYNC_STAGES-1];
  end

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Leading edge leaves the idle level CPOL, trailing edge returns to it.
  assign cs_fall     = cs_dly_q & ~cs_s;
  assign lead_edge   = (sclk_dly_q == CPOL) && (sclk_s != CPOL);
  assign trail_edge  = (sclk_dly_q != CPOL) && (sclk_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_load     = 1'b0;
    tx_shift_en = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        tx_load    = 1'b1;
        bit_cnt_d  = '0;
        word_cnt_d = '0;
        state_d    = S_ACTIVE;
      end

      S_ACTIVE: begin
        // cs_n rising takes priority: any sclk edge seen in the same cycle is dropped.
        if (cs_s) begin
          state_d = S_END;
        end else if (sample_edge) begin
          rx_shift_d = MSB_FIRST ? {rx_shift_q[DATA_W-2:0], mosi_s}
                                 : {mosi_s, rx_shift_q[DATA_W-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d  = rx_shift_d;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            word_cnt_d = (word_cnt_q == {CNT_W{1'b1}}) ? word_cnt_q : word_cnt_q + 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (shift_edge) begin
          // With CPHA=1 the first leading edge of a frame finds the LOAD word already on miso.
          if (bit_cnt_q != '0) begin
            tx_shift_en = 1'b1;
          end else if (!CPHA || (word_cnt_q != '0)) begin
            tx_load = 1'b1;
          end
        end
      end

      S_END: begin
        bit_cnt_d = '0;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    tx_shift_d = tx_shift_q;
    if (tx_load) begin
      tx_shift_d = bus.tx_valid ? bus.tx_data : TX_IDLE;
    end else if (tx_shift_en) begin
      tx_shift_d = MSB_FIRST ? {tx_shift_q[DATA_W-2:0], 1'b0}
                             : {1'b0, tx_shift_q[DATA_W-1:1]};
    end
  end

  assign miso_oe_d = (state_d == S_ACTIVE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cs_sync_q   <= {SYNC_STAGES{1'b1}};
      sclk_sync_q <= {SYNC_STAGES{CPOL}};
      mosi_sync_q <= '0;
      cs_dly_q    <= 1'b1;
      sclk_dly_q  <= CPOL;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_oe_q   <= 1'b0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_dly_q    <= cs_dly_d;
      sclk_dly_q  <= sclk_dly_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_oe_q   <= miso_oe_d;
    end
  end

  assign tx_bit        = MSB_FIRST ? tx_shift_q[DATA_W-1] : tx_shift_q[0];
  assign miso          = miso_oe_q & tx_bit;
  assign miso_oe       = miso_oe_q;
  assign bus.tx_ready  = tx_load & bus.tx_valid;
  assign tx_underrun   = tx_load & ~bus.tx_valid;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.state_dbg = state_q;
  assign frame_done    = (state_q == S_END);
  assign frame_abort   = (state_q == S_END) && (bit_cnt_q != '0);
  assign word_cnt      = word_cnt_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: doc/spi_slave_frame.md
Name: spi_slave_frame

Overview:
Parametrised SPI slave for multi-word frames. Supports configurable word width, all four CPOL/CPHA modes, and a selectable bit order. It synchronises the external pins into the sys_clk domain and deserialises MOSI into words delivered on a valid-pulse interface. Transmit words are fetched from a valid/ready source and serialised onto MISO. It sits between the board SPI pins and the register/protocol layer, and supports back-to-back words inside one cs_n assertion, with underrun and abort reporting.

Parameters:
DATA_W, 8, word width in bits (4..32).
CPOL, 1'b1, idle level of sclk.
CPHA, 1'b1, 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge.
MSB_FIRST, 1'b1, 1 = MSB shifted first, 0 = LSB shifted first.
SYNC_STAGES, 2, flop stages on cs_n, sclk and mosi (minimum 2).
TX_IDLE, all zeros (DATA_W bits), word transmitted when no tx word is available.
CNT_W, 8, width of word_cnt.

Ports:
sys_clk  in  1  system clock.
sys_rst_n  in  1  asynchronous, active-low reset.
cs_n  in  1  chip select, active low, asynchronous to sys_clk.
sclk  in  1  SPI clock, asynchronous.
mosi  in  1  master-out data, asynchronous.
miso  out  1  slave-out data.
miso_oe  out  1  MISO output enable, high while the frame is active.
tx_data  in  DATA_W  next word to transmit.
tx_valid  in  1  tx_data is available.
tx_ready  out  1  one-cycle pulse; tx_data is consumed in the cycle where tx_valid & tx_ready.
rx_data  out  DATA_W  last complete received word; held until the next word completes.
rx_valid  out  1  one-cycle pulse when rx_data updates.
tx_underrun  out  1  one-cycle pulse when TX_IDLE is loaded because tx_valid was low.
frame_done  out  1  one-cycle pulse on cs_n deassertion that ends a frame.
frame_abort  out  1  one-cycle pulse when cs_n deasserts with a partial word (bit_cnt != 0).
word_cnt  out  CNT_W  number of complete words received in the current frame; saturates at its maximum value.
busy  out  1  high while the state machine is not IDLE.

Behaviour:
- Reset values: all outputs 0. Synchroniser reset values: cs_n = 1, sclk = CPOL, mosi = 0. Shift registers and bit_cnt reset to 0.
- Synchronisers: each pin passes through SYNC_STAGES flops. Edge detection compares the last stage with one extra delay flop. The leading edge is the transition away from CPOL; the trailing edge is the transition back to CPOL. Sample edge = leading if CPHA = 0, else trailing. Shift edge = the other edge.
- Timing requirement: each sclk half-period must last at least SYNC_STAGES + 2 sys_clk cycles, and cs_n setup/hold must be at least SYNC_STAGES + 2 cycles. Behaviour outside these limits is undefined.
- FSM states:
  - IDLE: waits for synced cs_n to fall, then goes to LOAD.
  - LOAD: one cycle. Performs a tx load (see below) and clears bit_cnt and word_cnt. Goes to ACTIVE.
  - ACTIVE: processes sclk edges. Goes to END when synced cs_n rises.
  - END: one cycle. Asserts frame_done, plus frame_abort if bit_cnt != 0. Clears bit_cnt. Goes to IDLE.
  - Any state: if cs_n is high in IDLE, the FSM stays in IDLE. sclk edges outside ACTIVE are ignored.
- Tx load: if tx_valid = 1, tx_shift takes tx_data and tx_ready pulses in the same cycle. Otherwise tx_shift takes TX_IDLE and tx_underrun pulses.
- miso output: miso = tx_shift[DATA_W-1] when MSB_FIRST = 1, else tx_shift[0]. miso is 0 when miso_oe = 0. For CPHA = 0, the first bit is on miso one cycle after LOAD, before the first sclk edge.
- Sample edge (ACTIVE):
  - rx_shift shifts in mosi, in the direction set by MSB_FIRST.
  - If bit_cnt = DATA_W-1: rx_data takes the completed word and rx_valid pulses in the next cycle. bit_cnt wraps to 0 and word_cnt increments.
  - Otherwise bit_cnt increments.
- Shift edge (ACTIVE):
  - CPHA = 0: bit_cnt = 0 (a word just completed) → tx load; else shift tx_shift by one.
  - CPHA = 1: bit_cnt = 0 and word_cnt = 0 → no action (the word from LOAD is already presented); bit_cnt = 0 and word_cnt != 0 → tx load; else shift.
- Simultaneous events: if the cs_n rise and an sclk edge are detected in the same cycle, the cs_n rise wins and the edge is discarded.
- rx_valid and frame_done may pulse in the same cycle only if the word completion is detected earlier; the word completion always reports first.
- Abort: on frame_abort, the partial rx word is discarded (rx_data unchanged, no rx_valid). A tx word consumed for a partially sent word is not re-requested.
- Asynchronous reset mid-frame: returns to IDLE immediately, with outputs at their reset values. A still-low cs_n is then treated as a new frame start once the synchroniser shows cs_n falling. Because the synchroniser resets to 1, a low cs_n appears as a fall after SYNC_STAGES cycles.
- Latency: rx_valid rises SYNC_STAGES + 2 sys_clk cycles after the pin edge of the last sample.

Test Plan:
- Mode 3, DATA_W = 8, MSB first: tx_valid with 0x3C; master sends 0xA5 → rx_data = 0xA5, one rx_valid pulse, master reads 0x3C, word_cnt = 1, one frame_done pulse, no frame_abort.
- Mode 0 two-word burst: tx words 0x12 then 0x34 both valid; master sends 0xF0, 0x0F in one cs_n → rx_valid twice (0xF0, 0x0F), master reads 0x12 then 0x34, exactly two tx_ready pulses, word_cnt = 2.
- Underrun, mode 1: one tx word 0x81, then tx_valid low; 2-word frame → master reads 0x81 then 0x00, one tx_underrun pulse at the second word's first shift edge.
- Abort: mode 3, cs_n rises after 5 sclk cycles of 0xFF → frame_abort = 1, frame_done = 1, no rx_valid, rx_data keeps its previous value; the next full frame of 0x5A is received correctly.
- DATA_W = 16, MSB_FIRST = 0, mode 2: master sends 0xBEEF LSB first → rx_data = 0xBEEF; tx 0xCAFE is seen LSB first at the master.
- Reset mid-word: sys_rst_n pulsed low after 3 bits with cs_n held low → all outputs 0; after release, a new frame starts and a full 8-bit word is received correctly.
